// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command responder: opcodes, header layout,
// NAK marker and FSM state encoding.
package uart_cmd_pkg;

    localparam int unsigned DataWidth = 16;
    localparam int unsigned NumRegs   = 16;
    localparam int unsigned AddrWidth = 4;
    localparam int unsigned LenWidth  = 8;

    // Header word layout: {op[15:12], addr[11:8], len[7:0]}
    localparam int unsigned OpMsb   = 15;
    localparam int unsigned OpLsb   = 12;
    localparam int unsigned AddrMsb = 11;
    localparam int unsigned AddrLsb = 8;
    localparam int unsigned LenMsb  = 7;
    localparam int unsigned LenLsb  = 0;

    localparam logic [3:0] OpWrite    = 4'h1;
    localparam logic [3:0] OpRead     = 4'h2;
    localparam logic [3:0] OpEcho     = 4'h3;
    localparam logic [3:0] OpChecksum = 4'h4;

    // Replaces the opcode nibble of a rejected header
    localparam logic [3:0] NakNibble = 4'hE;

    typedef enum logic [2:0] {
        StIdle,
        StHdrRd,
        StHdrCap,
        StRespHdr,
        StPayRd,
        StPayCap,
        StDataWr,
        StSumWr
    } state_t;

    function automatic logic is_valid_op(input logic [3:0] op);
        return (op == OpWrite) || (op == OpRead) || (op == OpEcho) || (op == OpChecksum);
    endfunction

endpackage

// File: rtl/cmd_reg_bank.sv
// 16 x 16 register bank: one synchronous write port, two combinational read
// ports (one for the command FSM, one for debug).
module cmd_reg_bank
    import uart_cmd_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic [DataWidth-1:0] rdata_o,
    input  logic [AddrWidth-1:0] dbg_addr_i,
    output logic [DataWidth-1:0] dbg_data_o
);

    logic [DataWidth-1:0] mem_q [NumRegs];

    // Storage: synchronous clear, single write port
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Reads see the pre-write value during a same-cycle write
    assign rdata_o    = mem_q[raddr_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/uart_cmd_responder.sv
// Frame-level command responder sitting between a UART RX FIFO and TX FIFO.
// Parses a header word, acknowledges or NAKs it, then services the payload
// against a 16 x 16 register bank.
module uart_cmd_responder
    import uart_cmd_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_empty,
    input  logic [DataWidth-1:0] read_rx_data,
    output logic                 enable_rx_read,
    input  logic                 tx_full,
    output logic [DataWidth-1:0] write_tx_data,
    output logic                 enable_tx_write,
    input  logic [AddrWidth-1:0] dbg_addr,
    output logic [DataWidth-1:0] dbg_data,
    output logic                 busy,
    output logic [7:0]           nak_count
);

    state_t                state_q, state_d;
    logic [3:0]            op_q, op_d;
    logic [11:0]           hdr_q, hdr_d;   // addr and len fields of the header
    logic [AddrWidth-1:0]  ptr_q, ptr_d;   // current register address
    logic [LenWidth-1:0]   cnt_q, cnt_d;   // words still to service
    logic [DataWidth-1:0]  sum_q, sum_d;
    logic [DataWidth-1:0]  data_q, data_d; // echo word held between PAY_CAP and DATA_WR
    logic [7:0]            nak_q, nak_d;

    logic                  rd_stb;
    logic                  wr_stb;
    logic [DataWidth-1:0]  tx_word;
    logic                  reg_we;
    logic [DataWidth-1:0]  reg_rdata;
    logic                  last_word;

    assign last_word = (cnt_q == 8'd1);

    cmd_reg_bank u_reg_bank (
        .clk_i      (clk),
        .rst_i      (reset),
        .we_i       (reg_we),
        .waddr_i    (ptr_q),
        .wdata_i    (read_rx_data),
        .raddr_i    (ptr_q),
        .rdata_o    (reg_rdata),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    // Next-state, datapath updates and FIFO strobes
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hdr_d   = hdr_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        data_d  = data_q;
        nak_d   = nak_q;
        rd_stb  = 1'b0;
        wr_stb  = 1'b0;
        tx_word = '0;
        reg_we  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_empty) begin
                    state_d = StHdrRd;
                end
            end

            StHdrRd: begin
                if (!rx_empty) begin
                    rd_stb  = 1'b1;
                    state_d = StHdrCap;
                end
            end

            StHdrCap: begin
                op_d    = read_rx_data[OpMsb:OpLsb];
                hdr_d   = read_rx_data[AddrMsb:LenLsb];
                ptr_d   = read_rx_data[AddrMsb:AddrLsb];
                cnt_d   = read_rx_data[LenMsb:LenLsb];
                sum_d   = '0;
                state_d = StRespHdr;
            end

            StRespHdr: begin
                if (!tx_full) begin
                    wr_stb = 1'b1;
                    if (is_valid_op(op_q)) begin
                        tx_word = {op_q, hdr_q};
                    end else begin
                        tx_word = {NakNibble, hdr_q};
                        if (nak_q != 8'hFF) begin
                            nak_d = nak_q + 8'd1;
                        end
                    end
                    if (op_q == OpRead) begin
                        state_d = (cnt_q == '0) ? StIdle : StDataWr;
                    end else if (cnt_q != '0) begin
                        state_d = StPayRd;
                    end else if (op_q == OpChecksum) begin
                        state_d = StSumWr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            StPayRd: begin
                if (!rx_empty) begin
                    rd_stb  = 1'b1;
                    state_d = StPayCap;
                end
            end

            StPayCap: begin
                if (op_q == OpEcho) begin
                    // Count is decremented once the word has been sent back
                    data_d  = read_rx_data;
                    state_d = StDataWr;
                end else begin
                    if (op_q == OpWrite) begin
                        reg_we = 1'b1;
                        ptr_d  = ptr_q + 4'd1;
                    end
                    if (op_q == OpChecksum) begin
                        sum_d = sum_q + read_rx_data;
                    end
                    cnt_d = cnt_q - 8'd1;
                    if (!last_word) begin
                        state_d = StPayRd;
                    end else if (op_q == OpChecksum) begin
                        state_d = StSumWr;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end

            StDataWr: begin
                if (!tx_full) begin
                    wr_stb  = 1'b1;
                    tx_word = (op_q == OpEcho) ? data_q : reg_rdata;
                    ptr_d   = ptr_q + 4'd1;
                    cnt_d   = cnt_q - 8'd1;
                    if (last_word) begin
                        state_d = StIdle;
                    end else if (op_q == OpEcho) begin
                        state_d = StPayRd;
                    end else begin
                        state_d = StDataWr;
                    end
                end
            end

            StSumWr: begin
                if (!tx_full) begin
                    wr_stb  = 1'b1;
                    tx_word = sum_q;
                    state_d = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Reset wins over anything the FSM would drive this cycle
        if (reset) begin
            rd_stb  = 1'b0;
            wr_stb  = 1'b0;
            tx_word = '0;
            reg_we  = 1'b0;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= '0;
            hdr_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            data_q  <= '0;
            nak_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            hdr_q   <= hdr_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            data_q  <= data_d;
            nak_q   <= nak_d;
        end
    end

    assign enable_rx_read  = rd_stb;
    assign enable_tx_write = wr_stb;
    assign write_tx_data   = tx_word;
    assign busy            = (state_q != StIdle) && !reset;
    assign nak_count       = nak_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: behavioural RX/TX FIFOs, frame
// vectors with hand-computed responses, and strobe-rule monitors.
module tb_uart_cmd_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [15:0] read_rx_data;
    logic        enable_rx_read;
    logic        tx_full;
    logic [15:0] write_tx_data;
    logic        enable_tx_write;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic        busy;
    logic [7:0]  nak_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] rx_mem [0:255];
    logic [15:0] tx_mem [0:255];
    int          wr_idx = 0;
    int          rd_idx = 0;
    int          tx_idx = 0;
    logic        rx_gap = 1'b0;
    logic        stress = 1'b0;
    int          scyc = 0;
    int          rx_viol = 0;
    int          tx_viol = 0;
    int          both_viol = 0;
    int          pend_viol = 0;
    logic        rd_prev = 1'b0;

    logic [15:0] rxv [0:4];
    logic [15:0] txv [0:4];

    always #5 clk = ~clk;

    uart_cmd_responder dut (
        .clk             (clk),
        .reset           (reset),
        .rx_empty        (rx_empty),
        .read_rx_data    (read_rx_data),
        .enable_rx_read  (enable_rx_read),
        .tx_full         (tx_full),
        .write_tx_data   (write_tx_data),
        .enable_tx_write (enable_tx_write),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data),
        .busy            (busy),
        .nak_count       (nak_count)
    );

    assign rx_empty = (rd_idx == wr_idx) || rx_gap;

    // FIFO models and strobe-rule monitors
    always @(posedge clk) begin
        rd_prev <= enable_rx_read;
        if (enable_rx_read) begin
            if (rx_empty) rx_viol <= rx_viol + 1;
            if (rd_prev) pend_viol <= pend_viol + 1;
            read_rx_data <= rx_mem[rd_idx];
            rd_idx <= rd_idx + 1;
        end
        if (enable_tx_write) begin
            if (tx_full) tx_viol <= tx_viol + 1;
            tx_mem[tx_idx] <= write_tx_data;
            tx_idx <= tx_idx + 1;
        end
        if (enable_rx_read && enable_tx_write) both_viol <= both_viol + 1;
    end

    // Back-pressure pattern: tx_full toggles every 3 cycles, rx gaps 2 of 5
    always @(negedge clk) begin
        if (stress) begin
            scyc    <= scyc + 1;
            tx_full <= ((scyc / 3) % 2) == 1;
            rx_gap  <= (scyc % 5) < 2;
        end else begin
            scyc    <= 0;
            tx_full <= 1'b0;
            rx_gap  <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_rx(input logic [15:0] w);
        rx_mem[wr_idx] = w;
        wr_idx = wr_idx + 1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rd_idx == wr_idx && !busy) && n < 3000);
        check_eq({tag, "_idle"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check_eq(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    // Sends rxv[0..n_rx-1], then compares the response with txv[0..n_tx-1]
    task automatic run_frame(input string tag, input int n_rx, input int n_tx);
        int base;
        base = tx_idx;
        for (int i = 0; i < n_rx; i++) push_rx(rxv[i]);
        wait_idle(tag);
        repeat (2) @(negedge clk);
        check_eq({tag, "_ntx"}, tx_idx - base, n_tx);
        for (int i = 0; i < n_tx; i++) begin
            check_eq($sformatf("%s_tx%0d", tag, i), {16'h0, tx_mem[base + i]}, {16'h0, txv[i]});
        end
    endtask

    initial begin
        int base;
        int n;
        reset    = 1'b1;
        dbg_addr = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", {31'h0, busy}, 32'h0);
        check_eq("rst_rd_stb", {31'h0, enable_rx_read}, 32'h0);
        check_eq("rst_wr_stb", {31'h0, enable_tx_write}, 32'h0);
        check_eq("rst_tx_data", {16'h0, write_tx_data}, 32'h0);
        check_eq("rst_nak", {24'h0, nak_count}, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        check_reg("rst_reg5", 4'd5, 16'h0000);

        // WRITE two words at reg3
        rxv = '{16'h1302, 16'hBEEF, 16'hCAFE, 16'h0, 16'h0};
        txv = '{16'h1302, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame("wr3", 3, 1);
        check_reg("reg3", 4'd3, 16'hBEEF);
        check_reg("reg4", 4'd4, 16'hCAFE);

        // READ wrapping from reg15 to reg0 (both still clear)
        rxv = '{16'h2F02, 16'h0, 16'h0, 16'h0, 16'h0};
        txv = '{16'h2F02, 16'h0000, 16'h0000, 16'h0, 16'h0};
        run_frame("rdf", 1, 3);

        // READ back the written pair
        rxv = '{16'h2302, 16'h0, 16'h0, 16'h0, 16'h0};
        txv = '{16'h2302, 16'hBEEF, 16'hCAFE, 16'h0, 16'h0};
        run_frame("rd3", 1, 3);

        // WRITE wrapping 15 -> 0, then read it back
        rxv = '{16'h1F02, 16'h1234, 16'h5678, 16'h0, 16'h0};
        txv = '{16'h1F02, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame("wrf", 3, 1);
        check_reg("reg15", 4'd15, 16'h1234);
        check_reg("reg0", 4'd0, 16'h5678);
        rxv = '{16'h2F02, 16'h0, 16'h0, 16'h0, 16'h0};
        txv = '{16'h2F02, 16'h1234, 16'h5678, 16'h0, 16'h0};
        run_frame("rdf2", 1, 3);

        // CHECKSUM with carry discarded: FFFF + 0002 + 0001 = 0x0002
        rxv = '{16'h4003, 16'hFFFF, 16'h0002, 16'h0001, 16'h0};
        txv = '{16'h4003, 16'h0002, 16'h0, 16'h0, 16'h0};
        run_frame("sum", 4, 2);

        // INVALID opcode 7: NAK, payload discarded
        rxv = '{16'h7502, 16'h1111, 16'h2222, 16'h0, 16'h0};
        txv = '{16'hE502, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame("nak", 3, 1);
        check_eq("nak_cnt", {24'h0, nak_count}, 32'd1);
        check_reg("nak_reg5", 4'd5, 16'h0000);

        // ECHO under back-pressure and RX gaps
        stress = 1'b1;
        rxv = '{16'h3004, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        txv = '{16'h3004, 16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        run_frame("echo", 5, 5);
        stress = 1'b0;
        @(negedge clk);

        // Reset in the middle of a WRITE frame
        push_rx(16'h1002);
        push_rx(16'h5A5A);
        n = 0;
        while (rd_idx != wr_idx && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_eq("mid_consumed", (n < 1000) ? 32'd1 : 32'd0, 32'd1);
        repeat (2) @(negedge clk);
        check_reg("mid_reg0_pre", 4'd0, 16'h5A5A);
        check_eq("mid_busy_pre", {31'h0, busy}, 32'h1);
        base = tx_idx;
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_busy", {31'h0, busy}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("mid_busy_post", {31'h0, busy}, 32'h0);
        check_eq("mid_no_tx", tx_idx - base, 32'd0);
        check_reg("mid_reg0", 4'd0, 16'h0000);
        check_reg("mid_reg3", 4'd3, 16'h0000);
        check_eq("mid_nak", {24'h0, nak_count}, 32'd0);

        // Next frame works: CHECKSUM with len 0 still sends 0x0000
        rxv = '{16'h4000, 16'h0, 16'h0, 16'h0, 16'h0};
        txv = '{16'h4000, 16'h0000, 16'h0, 16'h0, 16'h0};
        run_frame("sum0", 1, 2);

        // WRITE with len 0 touches nothing
        rxv = '{16'h1700, 16'h0, 16'h0, 16'h0, 16'h0};
        txv = '{16'h1700, 16'h0, 16'h0, 16'h0, 16'h0};
        run_frame("wr0", 1, 1);

        check_eq("rx_strobe_empty", rx_viol, 32'd0);
        check_eq("tx_strobe_full", tx_viol, 32'd0);
        check_eq("strobe_overlap", both_viol, 32'd0);
        check_eq("rd_back_to_back", pend_viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
